imem_arbiter: RTL and testbench

//   Shares the single-port, synchronous-read instruction memory between the pipeline fetch stage and the program loader.
//   The loader writes and reads back program words; fetch reads instructions.

---
 rtl/imem_arbiter_pkg.sv | 21 ++
 rtl/imem_arbiter_if.sv | 55 +++++
 rtl/imem_arbiter.sv | 124 ++++++++++++
 tb/tb_imem_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_pkg
// Description : Shared constants and types for the instruction-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_pkg;

  localparam int          IMEM_DEPTH  = 400;
  localparam int          IMEM_ADDR_W = 9;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;

  // Owner of the read issued in the previous cycle (whose data is on mem_rdata now)
  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_LOAD  = 2'd2
  } owner_t;

endpackage
`default_nettype wire

// File: rtl/imem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_arbiter_if
// Description : Fetch, loader and memory-side signals of the imem arbiter.
//               slave  = arbiter side, master = requesters / RAM side.
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_arbiter_if
  import imem_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W
);
  // fetch port
  logic              f_req;
  logic [31:0]       f_addr;
  logic              f_flush;
  logic              f_ready;
  logic              f_valid;
  logic [31:0]       f_instr;
  logic              f_oob;
  // loader port
  logic              l_req;
  logic              l_we;
  logic [ADDR_W-1:0] l_addr;
  logic [31:0]       l_wdata;
  logic              l_gnt;
  logic              l_rvalid;
  logic [31:0]       l_rdata;
  // memory port
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  f_req, f_addr, f_flush,
    output f_ready, f_valid, f_instr, f_oob,
    input  l_req, l_we, l_addr, l_wdata,
    output l_gnt, l_rvalid, l_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output f_req, f_addr, f_flush,
    input  f_ready, f_valid, f_instr, f_oob,
    output l_req, l_we, l_addr, l_wdata,
    input  l_gnt, l_rvalid, l_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface
`default_nettype wire

// File: rtl/imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : imem_arbiter
// Description : Shares a single-port synchronous-read instruction RAM between
//               the fetch stage and the program loader. One grant per cycle,
//               bounded fetch starvation, out-of-range handling, fetch flush.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int DEPTH        = IMEM_DEPTH,
  parameter int ADDR_W       = IMEM_ADDR_W,
  parameter int STARVE_LIMIT = 8
) (
  input  logic           clk,
  input  logic           reset,
  imem_arbiter_if.slave  bus
);

  localparam int              c_cnt_w      = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_cnt_w-1:0] c_starve_max = c_cnt_w'(STARVE_LIMIT);
  localparam logic [31:0]     c_depth      = 32'(DEPTH);

  owner_t             r_owner;
  logic [c_cnt_w-1:0] r_starve_cnt;
  logic               r_resp_oob;
  logic [31:0]        r_f_instr;
  logic [31:0]        r_l_rdata;

  logic               w_f_in_range;
  logic               w_l_in_range;
  logic               w_starved;
  logic               w_f_gnt;
  logic               w_l_gnt;
  logic               w_f_valid;
  logic               w_l_valid;
  logic [31:0]        w_resp_data;
  owner_t             w_owner_nxt;

  assign w_f_in_range = bus.f_addr < c_depth;
  assign w_l_in_range = {{(32-ADDR_W){1'b0}}, bus.l_addr} < c_depth;
  assign w_starved    = (r_starve_cnt == c_starve_max);

  // Grant: loader has priority unless fetch has waited STARVE_LIMIT loader grants.
  // Grants are forced off while reset is held so every output reads 0.
  assign w_f_gnt = !reset && bus.f_req && (!bus.l_req || w_starved);
  assign w_l_gnt = !reset && bus.l_req && !w_f_gnt;

  assign bus.f_ready = w_f_gnt;
  assign bus.l_gnt   = w_l_gnt;

  // Memory drive for the granted in-range access; idle bus is all zero
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (w_f_gnt && w_f_in_range) begin
      bus.mem_en   = 1'b1;
      bus.mem_addr = bus.f_addr[ADDR_W-1:0];
    end else if (w_l_gnt && w_l_in_range) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.l_we;
      bus.mem_addr  = bus.l_addr;
      bus.mem_wdata = bus.l_wdata;
    end
  end

  // Owner of this cycle's read; writes leave no response behind
  always_comb begin
    w_owner_nxt = OWN_NONE;
    if (w_f_gnt)
      w_owner_nxt = OWN_FETCH;
    else if (w_l_gnt && !bus.l_we)
      w_owner_nxt = OWN_LOAD;
  end

  // Response path: data arrives from the RAM one cycle after grant; an
  // out-of-range read returns NOP_INSTR instead of whatever the RAM shows.
  assign w_resp_data = r_resp_oob ? NOP_INSTR : bus.mem_rdata;
  assign w_f_valid   = (r_owner == OWN_FETCH) && !bus.f_flush;
  assign w_l_valid   = (r_owner == OWN_LOAD);

  assign bus.f_valid  = w_f_valid;
  assign bus.f_instr  = w_f_valid ? w_resp_data : r_f_instr;
  assign bus.f_oob    = w_f_valid && r_resp_oob;
  assign bus.l_rvalid = w_l_valid;
  assign bus.l_rdata  = w_l_valid ? w_resp_data : r_l_rdata;

  // Owner tracking and out-of-range tag for the response due next cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner    <= OWN_NONE;
      r_resp_oob <= 1'b0;
    end else begin
      r_owner    <= w_owner_nxt;
      r_resp_oob <= w_f_gnt ? !w_f_in_range : (w_l_gnt && !w_l_in_range);
    end
  end

  // Starvation counter: loader grants taken while fetch waits, saturating
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_starve_cnt <= '0;
    else if (w_f_gnt || !bus.f_req)
      r_starve_cnt <= '0;
    else if (w_l_gnt && !w_starved)
      r_starve_cnt <= r_starve_cnt + 1'b1;
  end

  // Data outputs hold the last delivered response while valid is low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_f_instr <= '0;
      r_l_rdata <= '0;
    end else begin
      if (w_f_valid) r_f_instr <= w_resp_data;
      if (w_l_valid) r_l_rdata <= w_resp_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_arbiter
// Description : Self-checking bench for imem_arbiter: directed scenarios plus
//               randomized traffic against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_arbiter;

  localparam int DEPTH  = 400;
  localparam int ADDR_W = 9;
  localparam int LIMIT  = 8;

  logic clk;
  logic reset;

  imem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  imem_arbiter #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment RAM: synchronous read, one access per cycle
  logic [31:0] ram [0:511];
  initial for (int i = 0; i < 512; i++) ram[i] = 32'hA000_0000 | i;
  initial bus.mem_rdata = '0;
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= ram[bus.mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic [31:0] ref_mem [0:DEPTH-1];
  initial for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'hA000_0000 | i;

  int          m_wait;       // loader grants taken while a fetch is waiting
  int          m_pend;       // 0 none, 1 fetch response due, 2 loader response due
  bit          m_pend_oob;
  logic [31:0] m_pend_data;
  logic [31:0] m_last_f;
  logic [31:0] m_last_l;

  // Compare at each falling edge, then advance the model to the next cycle
  always @(negedge clk) begin
    if (reset) begin
      chk("rst_f_ready",  bus.f_ready,  0);
      chk("rst_l_gnt",    bus.l_gnt,    0);
      chk("rst_f_valid",  bus.f_valid,  0);
      chk("rst_f_instr",  bus.f_instr,  0);
      chk("rst_f_oob",    bus.f_oob,    0);
      chk("rst_l_rvalid", bus.l_rvalid, 0);
      chk("rst_l_rdata",  bus.l_rdata,  0);
      chk("rst_mem_en",   bus.mem_en,   0);
      chk("rst_mem_we",   bus.mem_we,   0);
      chk("rst_mem_addr", 32'(bus.mem_addr), 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
      m_wait = 0; m_pend = 0; m_pend_oob = 0; m_pend_data = 0;
      m_last_f = 0; m_last_l = 0;
    end else begin
      bit fg, lg, f_in, l_in, e_en, e_we, e_fv, e_lv;
      logic [31:0] e_fi, e_lr, e_resp;
      f_in = bus.f_addr < DEPTH;
      l_in = int'(bus.l_addr) < DEPTH;
      fg   = bus.f_req && (!bus.l_req || m_wait == LIMIT);
      lg   = bus.l_req && !fg;
      e_en = (fg && f_in) || (lg && l_in);
      e_we = lg && l_in && bus.l_we;
      e_resp = m_pend_oob ? 32'h0 : m_pend_data;
      e_fv = (m_pend == 1) && !bus.f_flush;
      e_lv = (m_pend == 2);
      e_fi = e_fv ? e_resp : m_last_f;
      e_lr = e_lv ? e_resp : m_last_l;

      chk("f_ready",  bus.f_ready,  fg);
      chk("l_gnt",    bus.l_gnt,    lg);
      chk("mem_en",   bus.mem_en,   e_en);
      chk("mem_we",   bus.mem_we,   e_we);
      if (e_en) chk("mem_addr", 32'(bus.mem_addr), fg ? 32'(bus.f_addr[ADDR_W-1:0]) : 32'(bus.l_addr));
      if (e_we) chk("mem_wdata", bus.mem_wdata, bus.l_wdata);
      chk("f_valid",  bus.f_valid,  e_fv);
      chk("f_instr",  bus.f_instr,  e_fi);
      chk("f_oob",    bus.f_oob,    e_fv && m_pend_oob);
      chk("l_rvalid", bus.l_rvalid, e_lv);
      chk("l_rdata",  bus.l_rdata,  e_lr);

      m_last_f = e_fi;
      m_last_l = e_lr;
      m_pend = 0; m_pend_oob = 0; m_pend_data = 0;
      if (fg) begin
        m_pend = 1; m_pend_oob = !f_in;
        m_pend_data = f_in ? ref_mem[bus.f_addr] : 32'h0;
      end else if (lg && !bus.l_we) begin
        m_pend = 2; m_pend_oob = !l_in;
        m_pend_data = l_in ? ref_mem[bus.l_addr] : 32'h0;
      end
      if (e_we) ref_mem[bus.l_addr] = bus.l_wdata;
      if (fg || !bus.f_req) m_wait = 0;
      else if (lg && m_wait < LIMIT) m_wait++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int first_f, n_f, n_l;
    bit fg_s, lg_s;
    reset = 1'b1;
    bus.f_req = 0; bus.f_addr = 0; bus.f_flush = 0;
    bus.l_req = 0; bus.l_we = 0; bus.l_addr = 0; bus.l_wdata = 0;
    repeat (3) next_cycle();
    reset = 1'b0;
    next_cycle();

    // 1: back-to-back fetches 0..3
    for (int i = 0; i < 5; i++) begin
      bus.f_req = (i < 4); bus.f_addr = 32'(i);
      @(negedge clk);
      chk("t1_ready", bus.f_ready, (i < 4));
      chk("t1_we",    bus.mem_we, 0);
      if (i > 0) begin
        chk("t1_valid", bus.f_valid, 1);
        chk("t1_instr", bus.f_instr, 32'hA000_0000 + 32'(i - 1));
      end
      next_cycle();
    end
    bus.f_req = 0;

    // 2: loader write then read back @5
    bus.l_req = 1; bus.l_we = 1; bus.l_addr = 9'd5; bus.l_wdata = 32'h1234_5678;
    @(negedge clk); chk("t2_wgnt", bus.l_gnt, 1);
    next_cycle(); bus.l_we = 0;
    @(negedge clk); chk("t2_rgnt", bus.l_gnt, 1);
    next_cycle(); bus.l_req = 0;
    @(negedge clk);
    chk("t2_rvalid", bus.l_rvalid, 1);
    chk("t2_rdata",  bus.l_rdata, 32'h1234_5678);
    next_cycle();

    // 3: both requesting for 20 cycles
    bus.f_req = 1; bus.f_addr = 10; bus.l_req = 1; bus.l_we = 0; bus.l_addr = 9'd20;
    first_f = -1; n_f = 0; n_l = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.f_ready) begin n_f++; if (first_f < 0) first_f = c; end
      if (bus.l_gnt) n_l++;
      next_cycle();
    end
    chk("t3_first_fetch", 32'(first_f), 8);
    chk("t3_fetch_cnt",   32'(n_f), 2);
    chk("t3_load_cnt",    32'(n_l), 18);
    bus.f_req = 0; bus.l_req = 0;
    next_cycle();

    // 4: out-of-range fetch, last in-range fetch, out-of-range loader ops
    bus.f_req = 1; bus.f_addr = 400;
    @(negedge clk); chk("t4_ready", bus.f_ready, 1); chk("t4_en", bus.mem_en, 0);
    next_cycle(); bus.f_addr = 399;
    @(negedge clk);
    chk("t4_valid", bus.f_valid, 1); chk("t4_instr", bus.f_instr, 0);
    chk("t4_oob", bus.f_oob, 1);     chk("t4_en399", bus.mem_en, 1);
    next_cycle();
    bus.f_req = 0; bus.l_req = 1; bus.l_we = 1; bus.l_addr = 9'd450; bus.l_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("t4_valid399", bus.f_valid, 1); chk("t4_oob399", bus.f_oob, 0);
    chk("t4_instr399", bus.f_instr, 32'hA000_018F);
    chk("t4_lw_gnt", bus.l_gnt, 1); chk("t4_lw_en", bus.mem_en, 0);
    next_cycle(); bus.l_we = 0;
    @(negedge clk); chk("t4_lr_en", bus.mem_en, 0);
    next_cycle(); bus.l_req = 0;
    @(negedge clk); chk("t4_lr_valid", bus.l_rvalid, 1); chk("t4_lr_data", bus.l_rdata, 0);
    next_cycle();

    // 5: flush the response to fetch @7, fetch @8 unaffected
    bus.f_req = 1; bus.f_addr = 7;
    @(negedge clk); chk("t5_ready7", bus.f_ready, 1);
    next_cycle(); bus.f_addr = 8; bus.f_flush = 1;
    @(negedge clk); chk("t5_flushed", bus.f_valid, 0); chk("t5_ready8", bus.f_ready, 1);
    next_cycle(); bus.f_flush = 0; bus.f_req = 0;
    @(negedge clk); chk("t5_valid8", bus.f_valid, 1); chk("t5_instr8", bus.f_instr, 32'hA000_0008);
    next_cycle();

    // 6: reset right after a loader read grant
    bus.l_req = 1; bus.l_we = 0; bus.l_addr = 9'd5;
    @(negedge clk); chk("t6_gnt", bus.l_gnt, 1);
    next_cycle(); bus.l_req = 0; reset = 1;
    @(negedge clk); chk("t6_rvalid_rst", bus.l_rvalid, 0);
    next_cycle(); reset = 0;
    @(negedge clk); chk("t6_rvalid_after", bus.l_rvalid, 0);
    next_cycle(); bus.l_req = 1;
    @(negedge clk);
    next_cycle(); bus.l_req = 0;
    @(negedge clk); chk("t6_rvalid", bus.l_rvalid, 1); chk("t6_rdata", bus.l_rdata, 32'h1234_5678);
    next_cycle();

    // Randomized traffic; requests are held until granted
    fg_s = 1; lg_s = 1;
    for (int c = 0; c < 3000; c++) begin
      if (!bus.f_req || fg_s) begin
        bus.f_req  = ($urandom % 3) != 0;
        bus.f_addr = (($urandom % 16) == 0) ? $urandom : $urandom_range(0, 419);
      end
      if (!bus.l_req || lg_s) begin
        bus.l_req   = ($urandom % 2) != 0;
        bus.l_we    = ($urandom % 2) != 0;
        bus.l_addr  = (($urandom % 8) == 0) ? 9'($urandom_range(400, 511)) : 9'($urandom_range(0, 399));
        bus.l_wdata = $urandom;
      end
      bus.f_flush = ($urandom % 5) == 0;
      reset       = ($urandom % 400) == 0;
      @(negedge clk);
      fg_s = bus.f_ready;
      lg_s = bus.l_gnt;
      next_cycle();
    end
    reset = 0; bus.f_req = 0; bus.l_req = 0; bus.f_flush = 0;
    repeat (2) next_cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
